// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU opcodes/flag positions plus the multiply-sequencer state encoding.
// The flag defines are global so the datapath and the sequencer agree on bit positions.
`ifndef FLAGS_Z
`define FLAGS_Z 0
`define FLAGS_C 1
`define FLAGS_N 2
`define FLAGS_V 3
`endif

package alu_mul_seq_pkg;

    typedef enum logic [3:0] {
        FnNOP = 4'd0,
        FnA   = 4'd1,
        FnB   = 4'd2,
        FnADD = 4'd3,
        FnSUB = 4'd4,
        FnAND = 4'd5,
        FnOR  = 4'd6,
        FnXOR = 4'd7
    } alu_functions_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } mulseq_state_t;

    localparam int MULSEQ_WIDTH = 16;
    localparam int MULSEQ_CNT_W = 5;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-and-add multiplier that borrows the shared ALU one bit per grant.
// Handshake: AluReq stays high through RUN; an iteration commits only on an edge with AluGnt=1.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = MULSEQ_WIDTH,
    parameter int CNT_W = MULSEQ_CNT_W
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Ovf,
    output logic                 AluReq,
    input  logic                 AluGnt,
    output alu_functions_t       AluOp,
    output logic [WIDTH-1:0]     AluOp1,
    output logic [WIDTH-1:0]     AluOp2,
    input  logic [WIDTH-1:0]     AluResult,
    input  logic [3:0]           AluFlags,
    output mulseq_state_t        DbgState
);

    mulseq_state_t          r_state;
    mulseq_state_t          w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_m;
    logic [WIDTH-1:0]       r_p_hi;
    logic [WIDTH-1:0]       r_p_lo;
    logic [2*WIDTH-1:0]     r_product;
    logic                   w_carry;
    logic [WIDTH-1:0]       w_p_hi_nxt;
    logic [WIDTH-1:0]       w_p_lo_nxt;
    logic                   w_step;
    logic                   w_unused_flags;

    // Only the carry is consumed; the 17th sum bit re-enters at the top of P_hi.
    assign w_carry        = AluFlags[`FLAGS_C];
    assign w_unused_flags = ^(AluFlags & ~(4'b0001 << `FLAGS_C));
    assign w_p_hi_nxt     = {w_carry, AluResult[WIDTH-1:1]};
    assign w_p_lo_nxt     = {AluResult[0], r_p_lo[WIDTH-1:1]};
    assign w_step         = (r_state == MS_RUN) && AluGnt;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        Busy         = 1'b0;
        Done         = 1'b0;
        AluReq       = 1'b0;
        AluOp        = FnNOP;
        AluOp1       = '0;
        AluOp2       = '0;
        case (r_state)
            MS_IDLE: begin
                if (Start) begin
                    w_next_state = MS_RUN;
                end
            end
            MS_RUN: begin
                Busy   = 1'b1;
                AluReq = 1'b1;
                AluOp  = r_p_lo[0] ? FnADD : FnA;
                AluOp1 = r_p_hi;
                AluOp2 = r_m;
                if (AluGnt && (r_cnt == CNT_W'(1))) begin
                    w_next_state = MS_DONE;
                end
            end
            MS_DONE: begin
                Busy         = 1'b1;
                Done         = 1'b1;
                w_next_state = MS_IDLE;
            end
            default: begin
                w_next_state = MS_IDLE;
            end
        endcase
    end

    // Product is a separate copy so it holds the previous result across a new Start.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_cnt     <= '0;
            r_m       <= '0;
            r_p_hi    <= '0;
            r_p_lo    <= '0;
            r_product <= '0;
        end else if ((r_state == MS_IDLE) && Start) begin
            r_cnt  <= CNT_W'(WIDTH);
            r_m    <= Multiplicand;
            r_p_hi <= '0;
            r_p_lo <= Multiplier;
        end else if (w_step) begin
            r_cnt     <= r_cnt - CNT_W'(1);
            r_p_hi    <= w_p_hi_nxt;
            r_p_lo    <= w_p_lo_nxt;
            r_product <= {w_p_hi_nxt, w_p_lo_nxt};
        end
    end

    assign Product  = r_product;
    assign Ovf      = |r_product[2*WIDTH-1:WIDTH];
    assign DbgState = r_state;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a combinational shared-ALU model.
module tb_alu_mul_seq;
    import alu_mul_seq_pkg::*;

    logic           Clock = 1'b0;
    logic           nReset = 1'b0;
    logic           Start = 1'b0;
    logic [15:0]    Multiplicand = '0;
    logic [15:0]    Multiplier = '0;
    logic           Busy;
    logic           Done;
    logic [31:0]    Product;
    logic           Ovf;
    logic           AluReq;
    logic           AluGnt = 1'b0;
    alu_functions_t AluOp;
    logic [15:0]    AluOp1;
    logic [15:0]    AluOp2;
    logic [15:0]    AluResult;
    logic [3:0]     AluFlags;
    mulseq_state_t  DbgState;

    int checks = 0;
    int failures = 0;

    alu_mul_seq dut (
        .Clock(Clock), .nReset(nReset), .Start(Start),
        .Multiplicand(Multiplicand), .Multiplier(Multiplier),
        .Busy(Busy), .Done(Done), .Product(Product), .Ovf(Ovf),
        .AluReq(AluReq), .AluGnt(AluGnt), .AluOp(AluOp),
        .AluOp1(AluOp1), .AluOp2(AluOp2), .AluResult(AluResult),
        .AluFlags(AluFlags), .DbgState(DbgState)
    );

    always #5 Clock = ~Clock;

    // Shared ALU: combinational, carry only meaningful for ADD.
    always_comb begin
        logic [16:0] sum;
        sum       = 17'({1'b0, AluOp1} + {1'b0, AluOp2});
        AluResult = '0;
        AluFlags  = '0;
        case (AluOp)
            FnADD: begin
                AluResult          = sum[15:0];
                AluFlags[`FLAGS_C] = sum[16];
            end
            FnA:     AluResult = AluOp1;
            default: AluResult = '0;
        endcase
        AluFlags[`FLAGS_Z] = (AluResult == 16'h0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // mode 0: grant tied high; mode 1: grant high only on even positions.
    // extra_start: pulse Start again at RUN position 5 with different operands.
    task automatic run_mul(input logic [15:0] m, input logic [15:0] q, input int mode,
                           input bit extra_start, output int done_pos, output int req_cyc,
                           output int add_cyc, output int a_cyc, output int stall_chg,
                           output logic [31:0] prod, output logic ovf, output logic busy_d,
                           output logic req_d);
        logic [31:0] held;
        bit          check_hold;
        done_pos   = 0;
        req_cyc    = 0;
        add_cyc    = 0;
        a_cyc      = 0;
        stall_chg  = 0;
        check_hold = 1'b0;
        held       = '0;
        @(negedge Clock);
        Start        = 1'b1;
        Multiplicand = m;
        Multiplier   = q;
        @(negedge Clock);
        Start = 1'b0;
        for (int pos = 1; pos <= 100; pos++) begin
            if (check_hold && (Product !== held)) stall_chg++;
            check_hold = 1'b0;
            if (Done) begin
                done_pos = pos;
                break;
            end
            if (AluReq) req_cyc++;
            if (AluOp == FnADD) add_cyc++;
            if (AluOp == FnA) a_cyc++;
            if (extra_start) begin
                Start        = (pos == 5);
                Multiplicand = 16'hFFFF;
                Multiplier   = 16'hFFFF;
            end
            AluGnt = (mode == 0) ? 1'b1 : (pos % 2 == 0);
            if (!AluGnt) begin
                held       = Product;
                check_hold = 1'b1;
            end
            @(negedge Clock);
        end
        prod   = Product;
        ovf    = Ovf;
        busy_d = Busy;
        req_d  = AluReq;
        AluGnt = 1'b0;
        Start  = 1'b0;
    endtask

    initial begin
        int          dpos, rc, ac, fa, sc, extra_done;
        int          done1, done2;
        logic [31:0] p;
        logic        o, b, r;

        // Reset state
        @(negedge Clock);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_req", 32'(AluReq), 0);
        chk("rst_product", Product, 0);
        chk("rst_ovf", 32'(Ovf), 0);
        chk("rst_state", 32'(DbgState), 32'(MS_IDLE));
        @(negedge Clock);
        nReset = 1'b1;

        // Grant outside RUN is ignored
        AluGnt = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        chk("idle_gnt_op", 32'(AluOp), 32'(FnNOP));
        chk("idle_gnt_ops", {AluOp1, AluOp2}, 0);
        chk("idle_gnt_state", 32'(DbgState), 32'(MS_IDLE));
        AluGnt = 1'b0;

        // 1: 3 x 5, continuous grant
        run_mul(16'd3, 16'd5, 0, 1'b0, dpos, rc, ac, fa, sc, p, o, b, r);
        chk("t1_done_pos", dpos, 17);
        chk("t1_req_cycles", rc, 16);
        chk("t1_add_cycles", ac, 2);
        chk("t1_product", p, 32'h0000000F);
        chk("t1_ovf", 32'(o), 0);
        chk("t1_busy_at_done", 32'(b), 1);
        chk("t1_req_at_done", 32'(r), 0);
        @(negedge Clock);
        chk("t1_done_pulse", 32'(Done), 0);
        chk("t1_idle_busy", 32'(Busy), 0);

        // 2: carry on every add
        run_mul(16'hFFFF, 16'hFFFF, 0, 1'b0, dpos, rc, ac, fa, sc, p, o, b, r);
        chk("t2_done_pos", dpos, 17);
        chk("t2_add_cycles", ac, 16);
        chk("t2_product", p, 32'hFFFE0001);
        chk("t2_ovf", 32'(o), 1);

        // 3: alternating grant
        run_mul(16'h1234, 16'h0100, 1, 1'b0, dpos, rc, ac, fa, sc, p, o, b, r);
        chk("t3_done_pos", dpos, 33);
        chk("t3_req_cycles", rc, 32);
        chk("t3_stall_hold", sc, 0);
        chk("t3_product", p, 32'h00123400);
        chk("t3_ovf", 32'(o), 1);

        // 4: zero multiplier, second Start mid-run ignored
        run_mul(16'hABCD, 16'h0000, 0, 1'b1, dpos, rc, ac, fa, sc, p, o, b, r);
        chk("t4_done_pos", dpos, 17);
        chk("t4_fna_cycles", fa, 16);
        chk("t4_add_cycles", ac, 0);
        chk("t4_product", p, 0);
        chk("t4_ovf", 32'(o), 0);
        extra_done = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge Clock);
            if (Done || Busy) extra_done++;
        end
        chk("t4_single_done", extra_done, 0);

        // 5: reset at iteration 7
        @(negedge Clock);
        Start        = 1'b1;
        Multiplicand = 16'hFFFF;
        Multiplier   = 16'hFFFF;
        AluGnt       = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (6) @(negedge Clock);
        chk("t5_busy_before", 32'(Busy), 1);
        nReset = 1'b0;
        #1;
        chk("t5_busy_abort", 32'(Busy), 0);
        chk("t5_req_abort", 32'(AluReq), 0);
        chk("t5_done_abort", 32'(Done), 0);
        chk("t5_product_abort", Product, 0);
        AluGnt = 1'b0;
        @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);
        chk("t5_idle_after", 32'(DbgState), 32'(MS_IDLE));
        run_mul(16'd2, 16'd7, 0, 1'b0, dpos, rc, ac, fa, sc, p, o, b, r);
        chk("t5_done_pos", dpos, 17);
        chk("t5_product", p, 32'd14);

        // 6: Start held high, back-to-back
        @(negedge Clock);
        Start        = 1'b1;
        Multiplicand = 16'd1;
        Multiplier   = 16'd1;
        AluGnt       = 1'b1;
        done1 = 0;
        done2 = 0;
        for (int pos = 1; pos <= 40; pos++) begin
            @(negedge Clock);
            if (Done) begin
                chk("t6_product", Product, 32'd1);
                if (done1 == 0) done1 = pos;
                else if (done2 == 0) done2 = pos;
            end
            if (pos == 18) chk("t6_idle_gap", 32'(Busy), 0);
            if (pos == 19) chk("t6_rerun", 32'(AluReq), 1);
        end
        Start  = 1'b0;
        AluGnt = 1'b0;
        chk("t6_done1_pos", done1, 17);
        chk("t6_done2_pos", done2, 35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
